// File: rtl/shift_seq.sv
// shift_seq: multi-cycle LSL/LSR/ASR/ROR/ROL shifter applying at most STEP bits per clock; SHIFT_CARRY_EN adds carry_out
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int STEP = 3,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SW-1:0]    shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry_out
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, dout_q, dout_d;
  logic [WIDTH-1:0] step_res, rot_r, rot_l, asr;
  logic [2:0] op_q, op_d;
  logic [SW-1:0] rem_q, rem_d, s, neg_s;
`ifdef SHIFT_CARRY_EN
  logic carry_q, carry_d;
`endif
  // -s mod WIDTH is 0 when s is 0, so the rotate OR degenerates to acc itself
  always_comb begin
    s = (rem_q > STEP_W) ? STEP_W : rem_q;
    neg_s = -s;
    rot_r = (acc_q >> s) | (acc_q << neg_s);
    rot_l = (acc_q << s) | (acc_q >> neg_s);
    asr = $signed(acc_q) >>> s;
    step_res = op_q == OP_LSL ? acc_q << s :
               op_q == OP_LSR ? acc_q >> s :
               op_q == OP_ASR ? asr :
               op_q == OP_ROR ? rot_r :
               op_q == OP_ROL ? rot_l : acc_q;
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    op_d = op_q;
    rem_d = rem_q;
    dout_d = dout_q;
`ifdef SHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    if (state_q == SHIFT) begin
      acc_d = step_res;
      rem_d = rem_q - s;
      if (rem_q == s) begin
        state_d = DONE;
        dout_d = step_res;
`ifdef SHIFT_CARRY_EN
        // the final step's outgoing bit shows up in the wrapped position of a rotate
        carry_d = (s != '0) &&
                  ((op_q == OP_LSL || op_q == OP_ROL) ? rot_l[0] :
                   (op_q == OP_LSR || op_q == OP_ASR || op_q == OP_ROR) ? rot_r[WIDTH-1] : 1'b0);
`endif
      end
    end else if (start) begin
      acc_d = d_in;
      op_d = op;
      rem_d = shamt;
      state_d = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      op_q <= '0;
      rem_q <= '0;
      dout_q <= '0;
`ifdef SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      op_q <= op_d;
      rem_q <= rem_d;
      dout_q <= dout_d;
`ifdef SHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign d_out = dout_q;
`ifdef SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and randomized checks of shift_seq against a bit-level reference model
module tb_shift_seq;
  localparam int WIDTH = 32;
  localparam int STEP = 3;
  localparam int SW = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [2:0] op = '0;
  logic [WIDTH-1:0] d_in = '0;
  logic [SW-1:0] shamt = '0;
  logic busy, done;
  logic [WIDTH-1:0] d_out;
`ifdef SHIFT_CARRY_EN
  logic carry_out;
`endif
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  shift_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .d_in(d_in),
    .shamt(shamt),
    .busy(busy),
    .done(done),
    .d_out(d_out)
`ifdef SHIFT_CARRY_EN
    ,
    .carry_out(carry_out)
`endif
  );
  function automatic logic [WIDTH-1:0] ref_res(input logic [2:0] o, input logic [WIDTH-1:0] d, input int sh);
    logic [WIDTH-1:0] r;
    r = d;
    case (o)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = $signed(d) >>> sh;
      3'd3: for (int i = 0; i < WIDTH; i++) r[i] = d[(i + sh) % WIDTH];
      3'd4: for (int i = 0; i < WIDTH; i++) r[(i + sh) % WIDTH] = d[i];
      default: r = d;
    endcase
    return r;
  endfunction
  function automatic int ref_n(input int sh);
    return sh == 0 ? 1 : (sh + STEP - 1) / STEP;
  endfunction
  function automatic logic ref_carry(input logic [2:0] o, input logic [WIDTH-1:0] d, input int sh);
    logic [WIDTH-1:0] r;
    r = ref_res(o, d, sh);
    if (sh == 0 || o > 3'd4) return 1'b0;
    case (o)
      3'd0: return d[WIDTH - sh];
      3'd1, 3'd2: return d[sh - 1];
      3'd3: return r[WIDTH-1];
      default: return r[0];
    endcase
  endfunction
  // returns at the negedge just after the start edge; now=1 drives in the current cycle
  task automatic drive(input logic [2:0] o, input logic [WIDTH-1:0] d, input int sh, input bit now);
    if (!now) @(negedge clk);
    op = o;
    d_in = d;
    shamt = SW'(sh);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  // scrambles the operand inputs while waiting to show they are not resampled
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bc++;
      d_in = $urandom;
      op = 3'($urandom);
      shamt = SW'($urandom);
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) lat = -1;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (d_out !== '0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    reset_n = 1'b1;
  endtask
  task automatic test_lsr;
    int lat, bc;
    drive(3'd1, 32'h8000_0001, 5, 0);
    wait_done(lat, bc);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL lsr_latency: got %0d expected 2", lat); end
    vectors++; if (bc != 2) begin miscompares++; $display("FAIL lsr_busy_cycles: got %0d expected 2", bc); end
    vectors++; if (d_out !== 32'h0400_0000) begin miscompares++; $display("FAIL lsr_dout: got %h expected 04000000", d_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL lsr_busy_in_done: got %b expected 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL lsr_done_width: got %b expected 0", done); end
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    drive(3'd2, 32'h8000_0000, 31, 0);
    wait_done(lat, bc);
    vectors++; if (lat != 11) begin miscompares++; $display("FAIL asr_latency: got %0d expected 11", lat); end
    vectors++; if (d_out !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL asr_dout: got %h expected ffffffff", d_out); end
    drive(3'd3, 32'h0000_0001, 4, 1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_done(lat, bc);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL ror_latency: got %0d expected 2", lat); end
    vectors++; if (d_out !== 32'h1000_0000) begin miscompares++; $display("FAIL ror_dout: got %h expected 10000000", d_out); end
    drive(3'd4, 32'h8000_0001, 1, 1);
    wait_done(lat, bc);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL rol_latency: got %0d expected 1", lat); end
    vectors++; if (d_out !== 32'h0000_0003) begin miscompares++; $display("FAIL rol_dout: got %h expected 00000003", d_out); end
  endtask
  task automatic test_ignore_start;
    drive(3'd0, 32'hDEAD_BEEF, 0, 0);
    op = 3'd1;
    d_in = 32'h0F0F_0F0F;
    shamt = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", done); end
    vectors++; if (d_out !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL zero_dout: got %h expected deadbeef", d_out); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignored_start_busy: got %b expected 0", busy); end
    vectors++; if (d_out !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ignored_start_dout: got %h expected deadbeef", d_out); end
  endtask
  task automatic test_passthrough;
    int lat, bc;
    drive(3'd7, 32'h1234_5678, 7, 0);
    wait_done(lat, bc);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL pass_latency: got %0d expected 3", lat); end
    vectors++; if (d_out !== 32'h1234_5678) begin miscompares++; $display("FAIL pass_dout: got %h expected 12345678", d_out); end
  endtask
  task automatic test_reset_abort;
    int lat, bc, seen;
    drive(3'd0, 32'h0000_0001, 20, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", done); end
    vectors++; if (d_out !== '0) begin miscompares++; $display("FAIL abort_dout: got %h expected 0", d_out); end
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    drive(3'd0, 32'h0000_0001, 20, 0);
    wait_done(lat, bc);
    vectors++; if (lat != 7) begin miscompares++; $display("FAIL restart_latency: got %0d expected 7", lat); end
    vectors++; if (d_out !== 32'h0010_0000) begin miscompares++; $display("FAIL restart_dout: got %h expected 00100000", d_out); end
  endtask
`ifdef SHIFT_CARRY_EN
  task automatic test_carry;
    int lat, bc;
    drive(3'd1, 32'h0000_0010, 5, 0);
    wait_done(lat, bc);
    vectors++; if (d_out !== '0) begin miscompares++; $display("FAIL carry_lsr_dout: got %h expected 0", d_out); end
    vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL carry_lsr: got %b expected 1", carry_out); end
    drive(3'd0, 32'h4000_0000, 2, 0);
    wait_done(lat, bc);
    vectors++; if (d_out !== '0) begin miscompares++; $display("FAIL carry_lsl_dout: got %h expected 0", d_out); end
    vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL carry_lsl: got %b expected 1", carry_out); end
  endtask
`endif
  task automatic test_random;
    int lat, bc, sh;
    logic [2:0] o;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      sh = $urandom_range(0, WIDTH - 1);
      drive(o, d, sh, done === 1'b1 && $urandom_range(0, 1) == 1);
      wait_done(lat, bc);
      vectors++; if (lat != ref_n(sh)) begin miscompares++; $display("FAIL rand_latency op=%0d sh=%0d: got %0d expected %0d", o, sh, lat, ref_n(sh)); end
      vectors++; if (d_out !== ref_res(o, d, sh)) begin miscompares++; $display("FAIL rand_dout op=%0d d=%h sh=%0d: got %h expected %h", o, d, sh, d_out, ref_res(o, d, sh)); end
`ifdef SHIFT_CARRY_EN
      vectors++; if (carry_out !== ref_carry(o, d, sh)) begin miscompares++; $display("FAIL rand_carry op=%0d d=%h sh=%0d: got %b expected %b", o, d, sh, carry_out, ref_carry(o, d, sh)); end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_lsr();
    test_back_to_back();
    test_ignore_start();
    test_passthrough();
    test_reset_abort();
`ifdef SHIFT_CARRY_EN
    test_carry();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Parametrised, multi-cycle successor to the 32-bit 4:1-mux logical-right shifter.
- Generalises width, full shift range (0..WIDTH-1) and shift mode (LSL/LSR/ASR/ROR/ROL).
- Applies at most STEP bit positions per clock, so each stage stays a small mux.
- Sits beside the ALU; the datapath controller drives it with a start/done handshake.

Parameters:
- WIDTH, 32, data width in bits; power of two, at least 4.
- STEP, 3, maximum shift applied per cycle; 1 ≤ STEP ≤ WIDTH-1.
- SW, $clog2(WIDTH), shamt width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when idle.
- op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others pass-through.
- d_in  input  WIDTH  operand.
- shamt  input  SW  shift amount, 0..WIDTH-1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- d_out  output  WIDTH  result; held until the next completion.

Behaviour:
- Reset: on a clk edge with reset_n=0, force state=IDLE, busy=0, done=0, d_out=0, and clear acc, op_r and rem. Reset during SHIFT aborts the operation; no done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - acc←d_in, op_r←op, rem←shamt.
  - Next state SHIFT; busy=1 from edge k.
- SHIFT, each edge:
  - s = min(rem, STEP).
  - Shift acc by s according to op_r: LSL fills 0 at LSB; LSR fills 0 at MSB; ASR fills acc[WIDTH-1]; ROR/ROL rotate; pass-through leaves acc unchanged.
  - rem←rem-s. If rem-s==0, go to DONE and load d_out with the shifted value on the same edge.
  - A SHIFT visit always lasts N = max(1, ceil(shamt/STEP)) edges, so shamt=0 still takes 1 edge.
- DONE: lasts exactly one cycle, with done=1 and busy=0, then returns to IDLE.
- Start in DONE: accepted exactly as in IDLE, so back-to-back operations are allowed. done still pulses for one cycle; busy=1 from the next edge.
- Start while busy=1: ignored. Inputs are not sampled outside IDLE/DONE, so the operand may change freely during SHIFT.
- Latency: start sampled at edge k → done high from edge k+N to edge k+N+1. Issue interval is N+1 cycles.
- Reference result must equal the single-cycle equivalent:
  - LSL: d_in<<shamt.
  - LSR: d_in>>shamt.
  - ASR: $signed(d_in)>>>shamt.
  - ROR/ROL: rotation mod WIDTH.
- d_out changes only on the done-rising edge or on reset.
- The rem counter is SW bits and never underflows.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- When defined:
  - Adds output port carry_out (1 bit), updated on the same edge as d_out and reset to 0.
  - Value is the last bit shifted out: LSL d_in[WIDTH-shamt]; LSR/ASR d_in[shamt-1]; ROR result[WIDTH-1]; ROL result[0].
  - carry_out=0 when shamt=0 or op is pass-through.
  - It is computed from the latched operand at start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, STEP=3, LSR, d_in=0x8000_0001, shamt=5 → N=2; done one cycle, 2 edges after start edge; d_out=0x0400_0000; busy high exactly 2 cycles.
- ASR, d_in=0x8000_0000, shamt=31 → N=11; d_out=0xFFFF_FFFF. Then ROR 0x0000_0001 shamt=4 issued in the DONE cycle → d_out=0x1000_0000 with no idle gap. Then ROL 0x8000_0001 shamt=1 → d_out=0x0000_0003.
- LSL, d_in=0xDEAD_BEEF, shamt=0 → N=1; d_out=0xDEAD_BEEF. A start pulse with different data during SHIFT is ignored; d_out is unchanged by it.
- op=111, d_in=0x1234_5678, shamt=7 → pass-through after N=3; d_out=0x1234_5678.
- LSL 0x0000_0001, shamt=20, reset_n=0 asserted at 4th SHIFT edge → busy=0, done=0, d_out=0; no done pulse follows. A new start after reset release works normally.
- SHIFT_CARRY_EN defined, LSR d_in=0x0000_0010, shamt=5 → d_out=0x0000_0000, carry_out=1. LSL d_in=0x4000_0000, shamt=2 → d_out=0, carry_out=1.
